// File: rtl/uart_buffer_ctrl_pkg.sv
// Shared definitions for the UART buffer controller: FSM encoding and default
// idle-timeout derivation from the clock and baud rate.
package uart_buffer_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        LAUNCH  = 3'd2,
        WAIT_HI = 3'd3,
        WAIT_LO = 3'd4
    } state_t;

    localparam int unsigned CLK_FREQ   = 50_000_000;
    localparam int unsigned UART_BPS   = 115_200;
    localparam int unsigned CHAR_BITS  = 10;
    localparam int unsigned IDLE_CHARS = 10;

    // Divide first so the product stays inside 32 bits (434 * 100 = 43400).
    localparam int unsigned IDLE_TO_DEFAULT = (CLK_FREQ / UART_BPS) * CHAR_BITS * IDLE_CHARS;

endpackage

// File: rtl/uart_buffer_ctrl_sync_fifo_ram.sv
// Circular buffer with registered one-cycle read, occupancy level and
// registered fill flags derived from the next level.
module uart_buffer_ctrl_sync_fifo_ram #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned AF_THRESH = 12,
    localparam int unsigned ADDR_W   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W:0]   level,
    output logic              empty,
    output logic              full,
    output logic              almost_full
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   level_nxt;
    logic              wr_acc;

    // full is the registered flag, so a same-cycle read never makes room.
    assign wr_acc = wr_en && !full;

    always_comb begin
        level_nxt = level;
        if (wr_acc && !rd_en) begin
            level_nxt = level + (ADDR_W+1)'(1);
        end else if (!wr_acc && rd_en) begin
            level_nxt = level - (ADDR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            rd_data     <= '0;
            level       <= '0;
            empty       <= 1'b1;
            full        <= 1'b0;
            almost_full <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (rd_en) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + ADDR_W'(1);
            end
            level       <= level_nxt;
            empty       <= (level_nxt == '0);
            full        <= (level_nxt == (ADDR_W+1)'(DEPTH));
            almost_full <= (level_nxt >= (ADDR_W+1)'(AF_THRESH));
        end
    end

endmodule

// File: rtl/uart_buffer_ctrl.sv
// Buffers uart_rx words and forwards them to uart_tx over tx_en/tx_busy,
// with stream or burst (threshold / idle-timeout) release and sticky overflow.
module uart_buffer_ctrl
    import uart_buffer_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned AF_THRESH  = 12,
    parameter int unsigned BURST_LEN  = 8,
    parameter int unsigned IDLE_TO    = IDLE_TO_DEFAULT,
    parameter int unsigned BUSY_GUARD = 4,
    localparam int unsigned ADDR_W    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode_burst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              tx_busy,
    input  logic              clr_overflow,
    output logic              tx_en,
    output logic [DATA_W-1:0] tx_data,
    output logic [ADDR_W:0]   level,
    output logic              empty,
    output logic              full,
    output logic              almost_full,
    output logic              overflow
);

    localparam int unsigned IDLE_W  = $clog2(IDLE_TO + 1);
    localparam int unsigned GUARD_W = $clog2(BUSY_GUARD + 1);

    state_t             state;
    state_t             state_nxt;
    logic               mode_q;
    logic               draining;
    logic               release_ok;
    logic               rd_en;
    logic               write_ok;
    logic [IDLE_W-1:0]  idle_cnt;
    logic [GUARD_W-1:0] guard_cnt;

    uart_buffer_ctrl_sync_fifo_ram #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .AF_THRESH (AF_THRESH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (in_valid),
        .wr_data     (in_data),
        .rd_en       (rd_en),
        .rd_data     (tx_data),
        .level       (level),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full)
    );

    assign rd_en      = (state == FETCH);
    assign write_ok   = in_valid && !full;
    assign release_ok = mode_q ? draining : 1'b1;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (!empty && release_ok && !tx_busy) state_nxt = FETCH;
            FETCH:   state_nxt = LAUNCH;
            LAUNCH:  state_nxt = WAIT_HI;
            WAIT_HI: begin
                // Give up on a transmitter that never acknowledges.
                if (tx_busy) begin
                    state_nxt = WAIT_LO;
                end else if (guard_cnt == GUARD_W'(BUSY_GUARD - 1)) begin
                    state_nxt = IDLE;
                end
            end
            WAIT_LO: if (!tx_busy) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tx_en     <= 1'b0;
            mode_q    <= 1'b0;
            draining  <= 1'b0;
            idle_cnt  <= '0;
            guard_cnt <= '0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_nxt;
            tx_en     <= (state_nxt == LAUNCH);
            guard_cnt <= (state == WAIT_HI) ? guard_cnt + GUARD_W'(1) : '0;

            if (state == IDLE) begin
                mode_q <= mode_burst;
            end

            // A started burst drains fully even if the mode changes meanwhile.
            if (state == IDLE && empty) begin
                draining <= 1'b0;
            end else if (mode_q && ((level >= (ADDR_W+1)'(BURST_LEN)) ||
                                    (idle_cnt == IDLE_W'(IDLE_TO) && !empty))) begin
                draining <= 1'b1;
            end

            if (write_ok || draining) begin
                idle_cnt <= '0;
            end else if (!empty && idle_cnt != IDLE_W'(IDLE_TO)) begin
                idle_cnt <= idle_cnt + IDLE_W'(1);
            end

            if (in_valid && full) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_buffer_ctrl.sv
// Self-checking bench for uart_buffer_ctrl: queue-based reference model plus
// directed latency, fill, burst, guard, reset and randomized traffic.
module tb_uart_buffer_ctrl;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned AF     = 12;
    localparam int unsigned BL     = 8;
    localparam int unsigned ITO    = 300;
    localparam int unsigned BG     = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              mode_burst;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              tx_busy;
    logic              clr_overflow;
    logic              tx_en;
    logic [DATA_W-1:0] tx_data;
    logic [4:0]        level;
    logic              empty;
    logic              full;
    logic              almost_full;
    logic              overflow;

    uart_buffer_ctrl #(
        .DATA_W     (DATA_W),
        .DEPTH      (DEPTH),
        .AF_THRESH  (AF),
        .BURST_LEN  (BL),
        .IDLE_TO    (ITO),
        .BUSY_GUARD (BG)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mode_burst   (mode_burst),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .tx_busy      (tx_busy),
        .clr_overflow (clr_overflow),
        .tx_en        (tx_en),
        .tx_data      (tx_data),
        .level        (level),
        .empty        (empty),
        .full         (full),
        .almost_full  (almost_full),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int tx_count    = 0;
    int last_tx_cyc = 0;
    bit model_on    = 1'b0;
    bit exp_ovf     = 1'b0;
    logic [DATA_W-1:0] exp_q  [$];
    logic [DATA_W-1:0] rx_log [$];

    // Transmitter model: 0 = normal (busy after tx_en), 1 = busy stuck low, 2 = stuck high.
    int tx_kind   = 0;
    int busy_len  = 20;
    int busy_left = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        n_chk++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        tx_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (tx_kind == 1) begin
                tx_busy = 1'b0;
            end else if (tx_kind == 2) begin
                tx_busy = 1'b1;
            end else begin
                if (tx_en) busy_left = (busy_len == 0) ? int'($urandom_range(1, 30)) : busy_len;
                else if (busy_left > 0) busy_left--;
                tx_busy = (busy_left > 0);
            end
        end
    end

    // Reference model: accepted words queue in order; drops set sticky overflow.
    always @(posedge clk) begin
        bit drop;
        if (rst) begin
            exp_q.delete();
            exp_ovf  = 1'b0;
            model_on = 1'b1;
        end else if (model_on) begin
            drop = in_valid && (exp_q.size() == DEPTH);
            if (in_valid && !drop) exp_q.push_back(in_data);
            if (drop) exp_ovf = 1'b1;
            else if (clr_overflow) exp_ovf = 1'b0;
        end
    end

    // Compare process: every launched word must be the oldest buffered one,
    // and status must track the model occupancy on every cycle.
    always @(negedge clk) begin
        logic [DATA_W-1:0] w;
        logic [8:0] exp_st;
        if (model_on) begin
            if (tx_en) begin
                rx_log.push_back(tx_data);
                tx_count++;
                last_tx_cyc = cyc;
                chk("tx_has_word", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    w = exp_q.pop_front();
                    chk("tx_data_order", 64'(tx_data), 64'(w));
                end
            end
            exp_st = {5'(exp_q.size()), exp_q.size() == 0, exp_q.size() == DEPTH,
                      exp_q.size() >= AF, exp_ovf};
            chk("status{level,empty,full,af,ovf}",
                64'({level, empty, full, almost_full, overflow}), 64'(exp_st));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic push(input logic [DATA_W-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_rx(input int n, input int budget);
        int k = 0;
        while (rx_log.size() < n && k < budget) begin
            step();
            k++;
        end
        chk("wait_rx_count", 64'(rx_log.size()), 64'(n));
    endtask

    task automatic chk_reset_state(input string name);
        chk(name, 64'({tx_en, tx_data, level, empty, full, almost_full, overflow}),
            64'({1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0}));
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATA_W-1:0] sent [$];
        int t0;
        int tc;
        int k;

        rst = 1'b1; mode_burst = 1'b0; in_valid = 1'b0; in_data = '0; clr_overflow = 1'b0;
        steps(2);
        rst = 1'b0;
        chk_reset_state("reset_state");
        steps(3);

        // Stream latency
        rx_log.delete();
        t0 = cyc;
        push(8'hA5);
        k = 0;
        while (tx_count == 0 && k < 50) begin step(); k++; end
        chk("stream_latency", 64'(last_tx_cyc - t0), 64'd3);
        chk("stream_word", 64'(rx_log.size() > 0 ? rx_log[0] : 8'h00), 64'hA5);
        chk("stream_level_zero", 64'(level), 64'd0);
        steps(30);

        // Fill / overflow with transmitter held busy
        tx_kind = 2;
        steps(2);
        rx_log.delete();
        for (int i = 0; i < 18; i++) begin
            push(8'(i));
            if (i == 10) chk("af_low_at_11", 64'({level, almost_full}), 64'({5'd11, 1'b0}));
            if (i == 11) chk("af_at_12", 64'({level, almost_full}), 64'({5'd12, 1'b1}));
            if (i == 14) chk("not_full_15", 64'(full), 64'd0);
            if (i == 15) chk("full_16_no_ovf", 64'({full, overflow}), 64'({1'b1, 1'b0}));
            if (i == 16) chk("ovf_on_17th", 64'({level, overflow}), 64'({5'd16, 1'b1}));
        end
        tx_kind = 0;
        wait_rx(16, 2000);
        steps(60);
        chk("fill_no_extra", 64'(rx_log.size()), 64'd16);
        for (int i = 0; i < 16 && i < rx_log.size(); i++) chk("fill_order", 64'(rx_log[i]), 64'(i));
        clr_overflow = 1'b1;
        step();
        clr_overflow = 1'b0;
        chk("ovf_cleared", 64'(overflow), 64'd0);

        // Burst threshold
        mode_burst = 1'b1;
        steps(3);
        rx_log.delete();
        sent.delete();
        for (int i = 0; i < 7; i++) begin
            sent.push_back(8'($urandom));
            push(sent[i]);
        end
        steps(250);
        chk("burst_hold", 64'(rx_log.size()), 64'd0);
        sent.push_back(8'($urandom));
        push(sent[7]);
        wait_rx(8, 1000);
        for (int i = 0; i < 8 && i < rx_log.size(); i++) chk("burst_order", 64'(rx_log[i]), 64'(sent[i]));
        steps(30);

        // Burst idle timeout on a partial burst
        rx_log.delete();
        sent.delete();
        for (int i = 0; i < 3; i++) begin
            sent.push_back(8'($urandom));
            push(sent[i]);
        end
        t0 = cyc - 1;
        tc = tx_count;
        k = 0;
        while (tx_count == tc && k < 2 * ITO) begin step(); k++; end
        chk_rng("burst_timeout_latency", last_tx_cyc - t0, ITO + 2, ITO + 4);
        wait_rx(3, 500);
        for (int i = 0; i < 3 && i < rx_log.size(); i++) chk("timeout_order", 64'(rx_log[i]), 64'(sent[i]));
        mode_burst = 1'b0;
        steps(30);

        // Busy guard with pointer wrap
        tx_kind = 1;
        steps(3);
        rx_log.delete();
        for (int g = 0; g < 4; g++) begin
            for (int j = 0; j < 5; j++) push(8'(8'h40 + g * 5 + j));
            steps(12);
        end
        wait_rx(20, 1000);
        for (int i = 0; i < 20 && i < rx_log.size(); i++) chk("guard_order", 64'(rx_log[i]), 64'(8'h40 + i));
        tx_kind = 0;
        busy_len = 20;
        steps(10);

        // Reset in the middle of a transfer
        rx_log.delete();
        for (int i = 0; i < 6; i++) push(8'(8'h60 + i));
        wait_rx(1, 50);
        steps(8);
        chk("level_before_rst", 64'({level, tx_busy}), 64'({5'd5, 1'b1}));
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset_state("reset_mid_transfer");
        rx_log.delete();
        push(8'h3C);
        wait_rx(1, 100);
        chk("after_rst_word", 64'(rx_log.size() > 0 ? rx_log[0] : 8'h00), 64'h3C);
        steps(100);
        chk("after_rst_no_old", 64'(rx_log.size()), 64'd1);

        // Randomized traffic
        busy_len = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 400 == 0) begin
                mode_burst = 1'($urandom_range(0, 1));
                tx_kind    = ($urandom_range(0, 2) == 2) ? 1 : 0;
            end
            in_valid     = ($urandom_range(0, 99) < 40);
            in_data      = 8'($urandom);
            clr_overflow = ($urandom_range(0, 99) < 3);
            step();
        end
        in_valid = 1'b0;
        clr_overflow = 1'b0;
        mode_burst = 1'b0;
        tx_kind = 0;
        k = 0;
        while (exp_q.size() != 0 && k < 3000) begin step(); k++; end
        chk("random_drain_done", 64'(exp_q.size()), 64'd0);
        steps(10);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
